// File: rtl/branch_flag_if.sv
// Request/flag handshake bundle for branch_flag_gen.
// master = requester/consumer environment, slave = the flag generator.
interface branch_flag_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [DATA_W-1:0] in_rs;
  logic [DATA_W-1:0] in_rt;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_op;
  logic              out_sf;
  logic              out_zf;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_rs, in_rt, out_ready,
    input  in_ready, out_valid, out_op, out_sf, out_zf, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, out_ready,
    output in_ready, out_valid, out_op, out_sf, out_zf, out_err
  );
endinterface

// File: rtl/branch_flag_gen.sv
// Multi-cycle signed-compare flag generator (SF/ZF) for branch decisions, LSB-first chunked subtract.
// Optional macro ZERO_FAST_EN: compare-against-zero opcodes bypass the chunked subtract.
module branch_flag_gen #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  branch_flag_if.slave   bus
);

  // DATA_W must be an integer multiple of CHUNK_W.
  localparam int N     = DATA_W / CHUNK_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = DATA_W - 1;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_REGZ = 6'b000001;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] a_q, b_q, diff_q;
  logic [5:0]        op_q;
  logic              err_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx_q;
  logic              in_ready_q, out_valid_q, sf_q, zf_q;

  // Operand B selection and opcode classification for the incoming request.
  logic [DATA_W-1:0] sel_b;
  logic              sel_err;
`ifdef ZERO_FAST_EN
  logic              sel_fast;
`endif

  always_comb begin
    sel_b   = '0;
    sel_err = 1'b0;
`ifdef ZERO_FAST_EN
    sel_fast = 1'b0;
`endif
    case (bus.in_op)
      OP_BEQ, OP_BNE: sel_b = bus.in_rt;
      OP_REGZ, OP_BLEZ, OP_BGTZ: begin
`ifdef ZERO_FAST_EN
        sel_fast = 1'b1;
`endif
      end
      default: sel_err = 1'b1;
    endcase
  end

  // One slice of A - B = A + ~B + carry, spliced into the running difference.
  logic [CHUNK_W-1:0] a_slice, b_slice, sum;
  logic               carry_nxt;
  logic [DATA_W-1:0]  diff_nxt;
  logic               ovf;

  always_comb begin
    a_slice = a_q[idx_q*CHUNK_W +: CHUNK_W];
    b_slice = b_q[idx_q*CHUNK_W +: CHUNK_W];
    {carry_nxt, sum} = {1'b0, a_slice} + {1'b0, ~b_slice} + {{CHUNK_W{1'b0}}, carry_q};
    diff_nxt = diff_q;
    diff_nxt[idx_q*CHUNK_W +: CHUNK_W] = sum;
    ovf = (a_q[MSB] != b_q[MSB]) && (diff_nxt[MSB] != a_q[MSB]);
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sf_q        <= 1'b0;
      zf_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_rs;
            b_q        <= sel_b;
            op_q       <= bus.in_op;
            err_q      <= sel_err;
            carry_q    <= 1'b1;
            idx_q      <= '0;
            diff_q     <= '0;
            in_ready_q <= 1'b0;
`ifdef ZERO_FAST_EN
            if (sel_fast) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              zf_q        <= (bus.in_rs == '0);
              sf_q        <= bus.in_rs[MSB];
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end

        CALC: begin
          diff_q  <= diff_nxt;
          carry_q <= carry_nxt;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_W'(N - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            // Unsupported opcodes still run the full pass but never report a condition.
            zf_q        <= !err_q && (diff_nxt == '0);
            sf_q        <= !err_q && (diff_nxt[MSB] ^ ovf);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = op_q;
  assign bus.out_sf    = sf_q;
  assign bus.out_zf    = zf_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_branch_flag_gen.sv
// Directed-vector bench for branch_flag_gen; expected flags and latencies are hand-computed.
// Builds with or without ZERO_FAST_EN; zero-compare latency expectations follow the macro.
module tb_branch_flag_gen;

  localparam int LAT = 5;  // accepting edge + 4 compute edges
`ifdef ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_flag_if #(.DATA_W(32)) bus ();

  branch_flag_gen #(.DATA_W(32), .CHUNK_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        sf;
    logic        zf;
    logic        err;
    int          edges;
  } vec_t;

  // Wait for in_ready, present one request, then count edges (accepting edge included) to out_valid.
  task automatic do_req(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int edges);
    int guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sf !== 1'b0 ||
        bus.out_zf !== 1'b0 || bus.out_err !== 1'b0 || bus.out_op !== 6'b0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b sf=%b zf=%b err=%b op=%b, want rdy=1 rest 0",
               bus.in_ready, bus.out_valid, bus.out_sf, bus.out_zf, bus.out_err, bus.out_op);
    end
  endtask

  // Back-to-back directed compares; out_ready is already high when DONE is entered.
  task automatic test_compare();
    vec_t v[12];
    int   edges;
    v[0]  = '{6'b000100, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b0, LAT};
    v[1]  = '{6'b000101, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, LAT};
    v[2]  = '{6'b000001, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, ZLAT};
    v[3]  = '{6'b000001, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1, 1'b0, ZLAT};
    v[4]  = '{6'b000110, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, ZLAT};
    v[5]  = '{6'b000100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, LAT};
    v[6]  = '{6'b000101, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, LAT};
    v[7]  = '{6'b000100, 32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, LAT};
    v[8]  = '{6'b000100, 32'h0000_00FF, 32'h0000_0100, 1'b1, 1'b0, 1'b0, LAT};
    v[9]  = '{6'b000111, 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, ZLAT};
    v[10] = '{6'b111111, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, LAT};
    v[11] = '{6'b000000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, LAT};
    bus.out_ready = 1'b1;
    foreach (v[i]) begin
      do_req(v[i].op, v[i].rs, v[i].rt, edges);
      checks++;
      if (edges !== v[i].edges) begin
        failures++;
        $display("FAIL cmp%0d_latency: got %0d edges, want %0d", i, edges, v[i].edges);
      end
      checks++;
      if (bus.out_sf !== v[i].sf || bus.out_zf !== v[i].zf || bus.out_err !== v[i].err ||
          bus.out_op !== v[i].op) begin
        failures++;
        $display("FAIL cmp%0d_flags: got sf=%b zf=%b err=%b op=%b, want sf=%b zf=%b err=%b op=%b",
                 i, bus.out_sf, bus.out_zf, bus.out_err, bus.out_op,
                 v[i].sf, v[i].zf, v[i].err, v[i].op);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL cmp%0d_handshake: got vld=%b rdy=%b, want vld=0 rdy=1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int edges;
    bus.out_ready = 1'b0;
    do_req(6'b000111, 32'h0000_0010, 32'h0, edges);
    checks++;
    if (edges !== ZLAT) begin
      failures++;
      $display("FAIL bp_latency: got %0d edges, want %0d", edges, ZLAT);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.in_op    = 6'b000100;
        bus.in_rs    = 32'h0000_0005;
        bus.in_rt    = 32'h0000_0005;
        bus.in_valid = 1'b1;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sf !== 1'b0 || bus.out_zf !== 1'b0 ||
          bus.in_ready !== 1'b0 || bus.out_op !== 6'b000111) begin
        failures++;
        $display("FAIL bp_hold_c%0d: got vld=%b sf=%b zf=%b rdy=%b op=%b, want 1 0 0 0 000111",
                 c, bus.out_valid, bus.out_sf, bus.out_zf, bus.in_ready, bus.out_op);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_leak: got rdy=%b vld=%b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int edges;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_op    = 6'b111111;
    bus.in_rs    = 32'h8000_0000;
    bus.in_rt    = 32'h0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL calc_busy: got rdy=%b vld=%b, want rdy=0 vld=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sf !== 1'b0 ||
        bus.out_zf !== 1'b0 || bus.out_err !== 1'b0 || bus.out_op !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset: rdy=%b vld=%b sf=%b zf=%b err=%b op=%b, want rdy=1 rest 0",
               bus.in_ready, bus.out_valid, bus.out_sf, bus.out_zf, bus.out_err, bus.out_op);
    end
    @(negedge clk);
    rst = 1'b0;
    do_req(6'b000100, 32'h0000_0003, 32'h0000_0003, edges);
    checks++;
    if (edges !== LAT || bus.out_zf !== 1'b1 || bus.out_sf !== 1'b0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_req: got edges=%0d zf=%b sf=%b err=%b, want %0d 1 0 0",
               edges, bus.out_zf, bus.out_sf, bus.out_err, LAT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_compare();
    test_backpressure();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
